// File: rtl/led_pkg.sv
// Shared mode encoding and per-mode seed patterns for the LED pattern engine.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam int unsigned MAX_LEDS = 32;

    // Callers truncate the result to their own LED count.
    function automatic logic [MAX_LEDS-1:0] seed_pattern(input mode_e mode);
        logic [MAX_LEDS-1:0] seed;
        case (mode)
            MODE_CHASE, MODE_BOUNCE: seed = 32'd1;
            default:                 seed = '0;
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter; tick is high combinationally in the enabled wrap cycle.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("tick_prescaler: DIV must be at least 2");
    end

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = en && (r_cnt == LAST);
    assign tick   = w_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step strobe drives one of four runtime-selectable patterns.
import led_pkg::*;

module led_pattern_gen #(
    parameter int unsigned N_LEDS     = 8,
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned STEP_HZ    = 1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [1:0]        mode_i,
    input  logic              mode_load_i,
    output logic [1:0]        mode_o,
    output logic              tick_o,
    output logic [N_LEDS-1:0] led_o
);

    localparam int unsigned DIV = CLK_HZ / STEP_HZ;
    localparam logic [N_LEDS-1:0] PAT_ONE = N_LEDS'(1);

    if (N_LEDS < 1 || N_LEDS > MAX_LEDS) begin : g_leds_check
        $error("led_pattern_gen: N_LEDS must be in 1..32");
    end
    if (DIV < 2) begin : g_div_check
        $error("led_pattern_gen: CLK_HZ/STEP_HZ must be at least 2");
    end

    logic [N_LEDS-1:0] r_pat;
    logic              r_dir;
    mode_e             r_mode;
    logic              r_tick;

    logic              w_wrap;
    logic              w_step;
    logic [N_LEDS-1:0] w_pat_nxt;
    logic              w_dir_nxt;
    logic [N_LEDS-1:0] w_seed;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (enable_i),
        .clr  (mode_load_i),
        .tick (w_wrap)
    );

    // A coincident mode load discards the step.
    assign w_step = w_wrap && !mode_load_i;
    assign w_seed = N_LEDS'(seed_pattern(mode_e'(mode_i)));

    always_comb begin
        w_pat_nxt = r_pat;
        w_dir_nxt = r_dir;
        case (r_mode)
            MODE_TOGGLE: begin
                w_pat_nxt = ~r_pat;
            end
            MODE_CHASE: begin
                if (r_pat == '0) begin
                    w_pat_nxt = PAT_ONE;
                end else begin
                    w_pat_nxt = (r_pat << 1) | (r_pat >> (N_LEDS - 1));
                end
            end
            MODE_BOUNCE: begin
                if (r_pat == '0) begin
                    w_pat_nxt = PAT_ONE;
                    w_dir_nxt = 1'b0;
                end else if (N_LEDS == 1) begin
                    w_pat_nxt = PAT_ONE;
                end else if (!r_dir) begin
                    if (r_pat[N_LEDS-1]) begin
                        w_pat_nxt = r_pat >> 1;
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_pat_nxt = r_pat << 1;
                    end
                end else begin
                    if (r_pat[0]) begin
                        w_pat_nxt = r_pat << 1;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_pat_nxt = r_pat >> 1;
                    end
                end
            end
            MODE_COUNT: begin
                w_pat_nxt = r_pat + PAT_ONE;
            end
            default: begin
                w_pat_nxt = r_pat;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= '0;
            r_dir  <= 1'b0;
            r_mode <= MODE_TOGGLE;
            r_tick <= 1'b0;
        end else if (mode_load_i) begin
            r_mode <= mode_e'(mode_i);
            r_pat  <= w_seed;
            r_dir  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_step;
            if (w_step) begin
                r_pat <= w_pat_nxt;
                r_dir <= w_dir_nxt;
            end
        end
    end

    assign mode_o = r_mode;
    assign tick_o = r_tick;
    assign led_o  = ACTIVE_LOW ? ~r_pat : r_pat;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench: three engine instances (8 LEDs active-low, 8 LEDs active-high, 1 LED) on shared stimulus.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_i;
    logic [1:0] mode_i;
    logic       mode_load_i;

    logic [1:0] mode0, mode1, mode2;
    logic       tick0, tick1, tick2;
    logic [7:0] led0, led1;
    logic       led2;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LEDS (8), .CLK_HZ (10), .STEP_HZ (1), .ACTIVE_LOW (1'b1)
    ) u0 (
        .clk (clk), .rst (rst), .enable_i (enable_i), .mode_i (mode_i),
        .mode_load_i (mode_load_i), .mode_o (mode0), .tick_o (tick0), .led_o (led0)
    );

    led_pattern_gen #(
        .N_LEDS (8), .CLK_HZ (10), .STEP_HZ (1), .ACTIVE_LOW (1'b0)
    ) u1 (
        .clk (clk), .rst (rst), .enable_i (enable_i), .mode_i (mode_i),
        .mode_load_i (mode_load_i), .mode_o (mode1), .tick_o (tick1), .led_o (led1)
    );

    led_pattern_gen #(
        .N_LEDS (1), .CLK_HZ (10), .STEP_HZ (1), .ACTIVE_LOW (1'b1)
    ) u2 (
        .clk (clk), .rst (rst), .enable_i (enable_i), .mode_i (mode_i),
        .mode_load_i (mode_load_i), .mode_o (mode2), .tick_o (tick2), .led_o (led2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (tick0 === 1'b1) begin
                n = i;
                return;
            end
        end
        check("tick_timeout", {31'd0, tick0}, 32'd1);
    endtask

    // Pushes the expected pattern, waits for the step strobe, then pops and compares.
    task automatic expect_step(input string tag, input logic [7:0] pat, input int n_exp,
                               input bit chk_al0, input bit chk_one);
        int         n;
        logic [7:0] e;
        logic [7:0] e_inv;
        sb_q.push_back(pat);
        wait_tick(20, n);
        check({tag, "_period"}, n, n_exp);
        e     = sb_q.pop_front();
        e_inv = ~e;
        check({tag, "_led"}, led0, e_inv);
        if (chk_al0) check({tag, "_led_al0"}, led1, e);
        if (chk_one) check({tag, "_led_n1"}, {31'd0, led2}, 32'd0);
    endtask

    task automatic load_mode(input logic [1:0] m);
        mode_i      = m;
        mode_load_i = 1'b1;
        @(negedge clk);
        mode_load_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bounce_tbl [16];
        logic [7:0] hold0, hold1;
        int         ticks, changed;

        bounce_tbl = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        rst = 1'b1; enable_i = 1'b1; mode_load_i = 1'b0; mode_i = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_led", led0, 8'hFF);
        check("rst_led_al0", led1, 8'h00);
        check("rst_led_n1", {31'd0, led2}, 32'd1);
        check("rst_tick", {31'd0, tick0}, 32'd0);
        check("rst_mode", mode0, 2'd0);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            expect_step("toggle", (k % 2 == 0) ? 8'hFF : 8'h00, 10, 1'b1, 1'b0);
        end

        load_mode(2'd1);
        check("chase_seed", led0, 8'hFE);
        check("chase_mode", mode0, 2'd1);
        for (int k = 1; k <= 8; k++) begin
            expect_step("chase", 8'(1 << (k % 8)), 10, 1'b1, 1'b0);
        end

        load_mode(2'd2);
        check("bounce_seed", led0, 8'hFE);
        check("bounce_seed_n1", {31'd0, led2}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            expect_step("bounce", bounce_tbl[k], 10, 1'b1, 1'b1);
        end

        load_mode(2'd3);
        check("count_seed", led1, 8'h00);
        check("count_mode", mode1, 2'd3);
        for (int k = 1; k <= 256; k++) begin
            expect_step("count", 8'(k), (k == 101) ? 7 : 10, 1'b1, 1'b0);
            if (k == 100) begin
                repeat (3) @(negedge clk);
                enable_i = 1'b0;
                hold0    = led0;
                hold1    = led1;
                ticks    = 0;
                changed  = 0;
                repeat (25) begin
                    @(negedge clk);
                    if (tick0 !== 1'b0) ticks++;
                    if (led0 !== hold0 || led1 !== hold1) changed++;
                end
                check("freeze_ticks", ticks, 0);
                check("freeze_changes", changed, 0);
                check("freeze_value", led1, 8'd100);
                enable_i = 1'b1;
            end
        end

        // Load TOGGLE exactly in the wrap cycle: seed 0 wins over the count step to 1.
        repeat (9) @(negedge clk);
        load_mode(2'd0);
        check("wrapload_tick", {31'd0, tick0}, 32'd0);
        check("wrapload_led", led0, 8'hFF);
        check("wrapload_led_al0", led1, 8'h00);
        check("wrapload_mode", mode0, 2'd0);
        expect_step("wrapload_next", 8'hFF, 10, 1'b1, 1'b0);

        load_mode(2'd1);
        expect_step("chase2", 8'h02, 10, 1'b1, 1'b0);

        // Reset with the prescaler at 5.
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_led", led0, 8'hFF);
        check("midrst_mode", mode0, 2'd0);
        check("midrst_tick", {31'd0, tick0}, 32'd0);
        expect_step("post_rst", 8'hFF, 10, 1'b1, 1'b0);

        load_mode(2'd0);
        check("reload_seed", led0, 8'hFF);
        expect_step("reload_step", 8'hFF, 10, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
